// File: rtl/apb_uart_host_if.sv
// APB bus between the UART host (initiator) and the UART slave port.
// The host drives select/enable/write/wdata; the slave returns rdata/ready.
interface apb_uart_host_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;

    modport master (output psel, penable, pwrite, pwdata, input prdata, pready);
    modport slave  (input psel, penable, pwrite, pwdata, output prdata, pready);
endinterface

// File: rtl/apb_uart_host.sv
// APB initiator servicing a UART: interrupt-driven reads into a small RX FIFO,
// client TX bytes forwarded as APB writes, with an ACCESS-phase timeout.
module apb_uart_host #(
    parameter int RX_DEPTH     = 4,
    parameter int TIMEOUT      = 16,
    parameter int INTR_HOLDOFF = 2
) (
    input  logic                   pclk,
    input  logic                   preset,
    apb_uart_host_if.master        apb,
    input  logic                   intr,
    input  logic                   tx_valid,
    input  logic [7:0]             tx_data,
    output logic                   tx_ready,
    output logic                   rx_valid,
    output logic [7:0]             rx_data,
    input  logic                   rx_ready,
    output logic                   timeout_err,
    output logic [1:0]             state_dbg
);
    localparam int PW = $clog2(RX_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(INTR_HOLDOFF + 2);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    // Handshakes: tx byte moves when tx_valid & tx_ready; rx head pops when
    // rx_valid & rx_ready; an APB transfer ends in ACCESS on pready or timeout.
    state_t        state;
    logic [7:0]    mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] acc_cnt;
    logic [HW-1:0] holdoff;

    logic rd_take, wr_take, push, pop, abort;

    assign rd_take   = (state == IDLE) && intr && (holdoff == '0) && (count != CW'(RX_DEPTH));
    assign wr_take   = (state == IDLE) && !rd_take && tx_valid && !preset;
    assign tx_ready  = wr_take;
    assign push      = (state == ACCESS) && apb.pready && !apb.pwrite;
    assign pop       = rx_ready && (count != '0);
    assign abort     = (state == ACCESS) && !apb.pready && (acc_cnt == TW'(TIMEOUT));
    assign state_dbg = state;
    assign rx_valid  = (count != '0);
    assign rx_data   = rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.pwdata  <= '0;
            timeout_err <= 1'b0;
            acc_cnt     <= '0;
            holdoff     <= '0;
        end else begin
            timeout_err <= 1'b0;
            if (holdoff != '0) holdoff <= holdoff - HW'(1);
            case (state)
                IDLE: begin
                    if (rd_take) begin
                        state      <= SETUP;
                        apb.psel   <= 1'b1;
                        apb.pwrite <= 1'b0;
                    end else if (wr_take) begin
                        state      <= SETUP;
                        apb.psel   <= 1'b1;
                        apb.pwrite <= 1'b1;
                        apb.pwdata <= tx_data;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    apb.penable <= 1'b1;
                    acc_cnt     <= TW'(1);
                end
                ACCESS: begin
                    if (apb.pready || abort) begin
                        state       <= IDLE;
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        timeout_err <= abort;
                        // Give the slave time to drop intr before another read.
                        if (!apb.pwrite) holdoff <= HW'(INTR_HOLDOFF);
                    end else begin
                        acc_cnt <= acc_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr] <= apb.prdata;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_uart_host.sv
// Directed bench for apb_uart_host: APB slave model, scoreboard queues for
// APB transfers and RX bytes, and cycle-level checks of the bus protocol.
module tb_apb_uart_host;
    logic       pclk = 1'b0;
    logic       preset;
    logic       intr, tx_valid, tx_ready, rx_valid, rx_ready, timeout_err;
    logic [7:0] tx_data, rx_data;
    logic [1:0] state_dbg;

    apb_uart_host_if bus();

    apb_uart_host dut (
        .pclk(pclk), .preset(preset), .apb(bus), .intr(intr),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    int tests = 0;
    int fails = 0;
    logic [8:0] exp_apb_q[$];   // {pwrite, pwdata}
    logic [7:0] exp_rx_q[$];

    logic       stall;
    int         slave_wait;
    logic [7:0] slave_base;
    int         wcnt = 0;
    int         rd_done = 0;
    int         te_cnt = 0;

    // clock / reset
    always #5 pclk = ~pclk;

    // slave model: pready after slave_wait ACCESS wait cycles; prdata walks up per read
    assign bus.pready = !stall && bus.psel && bus.penable && (wcnt == slave_wait);
    assign bus.prdata = slave_base + rd_done[7:0];

    always @(posedge pclk) begin
        if (bus.psel && bus.penable && !bus.pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (bus.psel && bus.penable && bus.pready && !bus.pwrite) rd_done <= rd_done + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic set_rdata(input logic [7:0] v);
        slave_base = v - rd_done[7:0];
    endtask

    // monitor / scoreboard
    always @(negedge pclk) begin
        logic [8:0] e;
        logic [7:0] r;
        if (!preset) begin
            if (bus.psel && bus.penable && bus.pready) begin
                if (exp_apb_q.size() == 0) check("apb_unexpected", 1, 0);
                else begin
                    e = exp_apb_q.pop_front();
                    check("apb_pwrite", 32'(bus.pwrite), 32'(e[8]));
                    if (e[8]) check("apb_pwdata", 32'(bus.pwdata), 32'(e[7:0]));
                end
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx_q.size() == 0) check("rx_unexpected", 1, 0);
                else begin
                    r = exp_rx_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(r));
                end
            end
            if (timeout_err) te_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, r0;
        preset = 1'b1; intr = 1'b0; tx_valid = 1'b1; tx_data = 8'hFF; rx_ready = 1'b0;
        stall = 1'b0; slave_wait = 0; slave_base = 8'h00;
        cyc(2);
        check("rst_psel", 32'(bus.psel), 0);
        check("rst_penable", 32'(bus.penable), 0);
        check("rst_pwrite", 32'(bus.pwrite), 0);
        check("rst_pwdata", 32'(bus.pwdata), 0);
        check("rst_tx_ready", 32'(tx_ready), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_state", 32'(state_dbg), 0);
        tx_valid = 1'b0;
        preset = 1'b0;
        cyc();

        // single write, pready on first ACCESS cycle
        tx_valid = 1'b1; tx_data = 8'hA5; slave_wait = 0;
        #1 check("wr_tx_ready", 32'(tx_ready), 1);
        exp_apb_q.push_back({1'b1, 8'hA5});
        cyc();
        check("wr_setup_psel", 32'(bus.psel), 1);
        check("wr_setup_penable", 32'(bus.penable), 0);
        check("wr_setup_pwrite", 32'(bus.pwrite), 1);
        check("wr_setup_pwdata", 32'(bus.pwdata), 32'hA5);
        check("wr_setup_tx_ready", 32'(tx_ready), 0);
        tx_valid = 1'b0; tx_data = 8'h00;
        cyc();
        check("wr_access_psel", 32'(bus.psel), 1);
        check("wr_access_penable", 32'(bus.penable), 1);
        check("wr_access_pwdata", 32'(bus.pwdata), 32'hA5);
        cyc();
        check("wr_done_psel", 32'(bus.psel), 0);
        check("wr_done_penable", 32'(bus.penable), 0);
        check("wr_done_timeout_err", 32'(timeout_err), 0);

        // read with 3 wait cycles, then holdoff suppresses a second read
        set_rdata(8'h3C); slave_wait = 3; intr = 1'b1;
        exp_apb_q.push_back({1'b0, 8'h00});
        exp_rx_q.push_back(8'h3C);
        cyc();
        check("rd_setup_psel", 32'(bus.psel), 1);
        check("rd_setup_penable", 32'(bus.penable), 0);
        check("rd_setup_pwrite", 32'(bus.pwrite), 0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.psel && bus.penable) n++;
        end
        check("rd_access_cycles", 32'(n), 4);
        cyc();
        check("rd_done_psel", 32'(bus.psel), 0);
        check("rd_rx_valid", 32'(rx_valid), 1);
        check("rd_rx_data", 32'(rx_data), 32'h3C);
        cyc();
        check("rd_holdoff1_psel", 32'(bus.psel), 0);
        cyc();
        check("rd_holdoff2_psel", 32'(bus.psel), 0);
        intr = 1'b0;
        cyc();
        check("rd_idle_psel", 32'(bus.psel), 0);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        check("rd_pop_empty", 32'(rx_valid), 0);

        // read has priority; pending write follows after one IDLE cycle
        slave_wait = 0; set_rdata(8'hC3); intr = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
        #1 check("pri_tx_ready_blocked", 32'(tx_ready), 0);
        exp_apb_q.push_back({1'b0, 8'h00});
        exp_apb_q.push_back({1'b1, 8'h5A});
        exp_rx_q.push_back(8'hC3);
        cyc();
        check("pri_first_is_read", 32'(bus.pwrite), 0);
        check("pri_setup_tx_ready", 32'(tx_ready), 0);
        cyc();
        intr = 1'b0;
        cyc();
        check("pri_idle_psel", 32'(bus.psel), 0);
        check("pri_tx_ready", 32'(tx_ready), 1);
        cyc();
        check("pri_write_psel", 32'(bus.psel), 1);
        check("pri_write_pwrite", 32'(bus.pwrite), 1);
        check("pri_write_pwdata", 32'(bus.pwdata), 32'h5A);
        tx_valid = 1'b0;
        cyc(2);
        check("pri_done_psel", 32'(bus.psel), 0);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;

        // FIFO full stalls reads; one pop lets a fifth read through
        r0 = rd_done; set_rdata(8'h01); slave_wait = 0; intr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_apb_q.push_back({1'b0, 8'h00});
            exp_rx_q.push_back(8'(i));
        end
        cyc(25);
        check("full_reads", 32'(rd_done - r0), 4);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.psel) n++;
        end
        check("full_no_psel", 32'(n), 0);
        check("full_head", 32'(rx_data), 32'h01);
        exp_apb_q.push_back({1'b0, 8'h00});
        exp_rx_q.push_back(8'h05);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        k = 0;
        while (rd_done != r0 + 5 && k < 20) begin
            cyc();
            k++;
        end
        check("full_fifth_read", 32'(rd_done - r0), 5);
        intr = 1'b0;
        cyc(3);
        rx_ready = 1'b1;
        cyc(4);
        rx_ready = 1'b0;
        check("full_drained", 32'(rx_valid), 0);

        // ACCESS timeout on a write, then normal service resumes
        stall = 1'b1; tx_valid = 1'b1; tx_data = 8'h77;
        #1 check("to_tx_ready", 32'(tx_ready), 1);
        cyc();
        tx_valid = 1'b0;
        check("to_setup_psel", 32'(bus.psel), 1);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (bus.psel && bus.penable && !timeout_err) n++;
        end
        check("to_access_cycles", 32'(n), 16);
        cyc();
        check("to_end_psel", 32'(bus.psel), 0);
        check("to_end_penable", 32'(bus.penable), 0);
        check("to_err_pulse", 32'(timeout_err), 1);
        cyc();
        check("to_err_clear", 32'(timeout_err), 0);
        stall = 1'b0; tx_valid = 1'b1; tx_data = 8'h88;
        #1 check("to_next_tx_ready", 32'(tx_ready), 1);
        exp_apb_q.push_back({1'b1, 8'h88});
        cyc();
        tx_valid = 1'b0;
        cyc(3);
        check("to_next_done", 32'(bus.psel), 0);

        // async reset mid-ACCESS of a read with two bytes buffered
        r0 = rd_done; set_rdata(8'h11); intr = 1'b1;
        exp_apb_q.push_back({1'b0, 8'h00});
        exp_apb_q.push_back({1'b0, 8'h00});
        k = 0;
        while (rd_done != r0 + 2 && k < 20) begin
            cyc();
            k++;
        end
        intr = 1'b0;
        check("rst_fill_reads", 32'(rd_done - r0), 2);
        check("rst_fill_head", 32'(rx_data), 32'h11);
        cyc(3);
        stall = 1'b1; intr = 1'b1;
        cyc(3);
        check("rst_pre_access", 32'(bus.penable), 1);
        preset = 1'b1;
        #1;
        check("rst_async_psel", 32'(bus.psel), 0);
        check("rst_async_penable", 32'(bus.penable), 0);
        check("rst_async_rx_valid", 32'(rx_valid), 0);
        intr = 1'b0; stall = 1'b0;
        cyc();
        preset = 1'b0;
        cyc(2);
        check("rst_after_psel", 32'(bus.psel), 0);
        check("rst_after_rx_valid", 32'(rx_valid), 0);
        set_rdata(8'h99);
        exp_apb_q.push_back({1'b0, 8'h00});
        exp_rx_q.push_back(8'h99);
        intr = 1'b1;
        cyc();
        intr = 1'b0;
        cyc(4);
        check("rst_new_head", 32'(rx_data), 32'h99);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        cyc(2);

        check("apb_q_drained", 32'(exp_apb_q.size()), 0);
        check("rx_q_drained", 32'(exp_rx_q.size()), 0);
        check("timeout_pulses", 32'(te_cnt), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_uart_host.md
Name: apb_uart_host

Overview:
- APB initiator that drives the UART's APB slave port on behalf of a local byte-stream client.
- Watches the UART interrupt and issues APB reads to fetch received bytes into a small RX FIFO.
- Issues APB writes for bytes offered on a local TX valid/ready interface.
- Sits between a processor-less client (or test harness) and the UART top, in the pclk domain.

Parameters:
- RX_DEPTH, 4, entries in the RX FIFO (power of two, >=2).
- TIMEOUT, 16, maximum ACCESS-phase cycles to wait for pready before aborting (>=2).
- INTR_HOLDOFF, 2, cycles after any read completion or abort during which intr is ignored.

Ports:
- pclk  in  1  clock; all logic rising-edge.
- preset  in  1  reset, asynchronous, active-high.
- intr  in  1  UART receive interrupt, level.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  1 = write, 0 = read.
- pwdata  out  8  APB write data.
- prdata  in  8  APB read data.
- pready  in  1  APB ready from the UART slave.
- tx_valid  in  1  client offers tx_data.
- tx_data  in  8  byte to transmit.
- tx_ready  out  1  byte accepted when tx_valid & tx_ready.
- rx_valid  out  1  RX FIFO non-empty.
- rx_data  out  8  RX FIFO head.
- rx_ready  in  1  client pops head when rx_valid & rx_ready.
- timeout_err  out  1  one-cycle pulse when a transfer is aborted.

Behaviour:
- Reset (async, immediate): psel=0, penable=0, pwrite=0, pwdata=0, tx_ready=0, rx_valid=0, rx_data=0, timeout_err=0. FIFO flushed, holdoff counter cleared, FSM to IDLE. Reset mid-transfer aborts the transfer with no push and no further handshake.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, read request: taken if intr=1, holdoff=0, and FIFO not full. Read has priority over write.
  - Next cycle enter SETUP with psel=1, penable=0, pwrite=0.
- IDLE, write request: taken if no read is taken and tx_valid=1.
  - tx_ready=1 combinationally in that cycle; tx_data is latched into pwdata.
  - Next cycle enter SETUP with psel=1, penable=0, pwrite=1.
  - tx_ready is 0 in every other state.
- SETUP: exactly one cycle, then ACCESS with psel=1, penable=1. pwrite and pwdata are held stable through SETUP and ACCESS.
- ACCESS: the transfer completes on the first cycle with pready=1. Next cycle psel=0, penable=0, back to IDLE.
  - Read completion: prdata is sampled in the pready cycle and pushed into the FIFO.
  - Minimum transfer is 2 cycles (SETUP + 1 ACCESS). Back-to-back transfers have one IDLE cycle between them.
- Timeout:
  - An ACCESS cycle counter starts at 1 on the first ACCESS cycle.
  - If the counter reaches TIMEOUT with pready still 0, that cycle is the last. Next cycle: psel=0, penable=0, IDLE, timeout_err=1 for one cycle.
  - Aborted read: nothing pushed. Aborted write: byte dropped, not retried.
- Holdoff: loaded with INTR_HOLDOFF on the cycle leaving ACCESS after a read (complete or aborted), then decrements to 0. This covers slave intr-clear latency and prevents double reads.
- RX FIFO:
  - rx_valid = (count != 0); rx_data = head entry.
  - Pointers wrap modulo RX_DEPTH; count width is clog2(RX_DEPTH)+1.
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - Pop when empty is ignored.
  - Push when full cannot occur: at most one read is in flight, and a read starts only when the FIFO is not full.
- intr and tx_valid are ignored outside IDLE. tx_data need not be held after the handshake.

Test Plan:
- Write: tx_valid=1, tx_data=0xA5, slave pready on 1st ACCESS cycle -> tx_ready pulse one cycle; psel high 2 cycles; penable high in 2nd; pwrite=1; pwdata=0xA5 throughout; timeout_err=0.
- Read: intr=1, prdata=0x3C, pready after 3 ACCESS wait cycles -> pwrite=0; FIFO push 0x3C; rx_valid=1, rx_data=0x3C next cycle; no second read during the INTR_HOLDOFF=2 cycles.
- Priority: intr=1 and tx_valid=1 in the same IDLE cycle -> read first. Write of the pending byte follows after one IDLE cycle once intr drops; tx_ready only at write start.
- FIFO full: intr held high, rx_ready=0, bytes 0x01..0x04 returned -> 4 reads, then psel stays 0. Pulse rx_ready one cycle -> pop 0x01, fifth read issued.
- Timeout: pready tied 0, write 0x77 -> ACCESS lasts exactly 16 cycles, then psel=penable=0 and a one-cycle timeout_err. The next tx_valid is serviced normally.
- Async reset mid-ACCESS on a read, with the FIFO holding 2 entries -> psel, penable, rx_valid = 0 immediately; FIFO empty after release; no push of in-flight data.
